// File: rtl/snake_pkg.sv
// Shared types, colours and helpers for the snake game core.
package snake_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'b00,
        DOWN  = 2'b01,
        UP    = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
    } cell_t;

    localparam logic [7:0] COL_APPLE = 8'h07;
    localparam logic [7:0] COL_HEAD  = 8'hFF;
    localparam logic [7:0] COL_DEAD  = 8'hE0;
    localparam logic [7:0] COL_BODY  = 8'h38;
    localparam logic [7:0] COL_BG    = 8'h40;
    localparam logic [7:0] COL_OFF   = 8'h00;

    // Starting layout: a horizontal line trailing left of the centre.
    function automatic cell_t init_cell(int i, int w, int h);
        cell_t c;
        int    xi;
        xi  = (((w / 2) - i) % w + w) % w;
        c.x = 7'(xi);
        c.y = 6'(h / 2);
        return c;
    endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control and pixel bus between game logic, VGA mux and the engine.
interface snake_engine_if #(
    parameter int LW = 6
);
    logic          TICK;
    logic          RUN;
    logic [1:0]    DIR;
    logic [6:0]    RAND_X;
    logic [5:0]    RAND_Y;
    logic [9:0]    ADDRH;
    logic [8:0]    ADDRV;
    logic [7:0]    COLOUR;
    logic          REACHED_TARGET;
    logic          COLLISION;
    logic [LW-1:0] LENGTH;
    logic [7:0]    SCORE;

    modport master (
        output TICK, RUN, DIR, RAND_X, RAND_Y,
        output ADDRH, ADDRV,
        input  COLOUR, REACHED_TARGET, COLLISION,
        input  LENGTH, SCORE
    );

    modport slave (
        input  TICK, RUN, DIR, RAND_X, RAND_Y,
        input  ADDRH, ADDRV,
        output COLOUR, REACHED_TARGET, COLLISION,
        output LENGTH, SCORE
    );
endinterface

// File: rtl/snake_segment_shifter.sv
// Segment shift buffer holding the snake body, with a length mask.
module snake_segment_shifter
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int GRID_W  = 80,
    parameter int GRID_H  = 60,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  init,
    input  logic                  shift,
    input  cell_t                 head_in,
    input  logic [LW-1:0]         len,
    output cell_t [MAX_LEN-1:0]   seg,
    output logic  [MAX_LEN-1:0]   active
);

    cell_t [MAX_LEN-1:0] seg_q;
    cell_t [MAX_LEN-1:0] seg_d;

    always_comb begin
        seg_d = seg_q;
        if (RESET || init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_d[i] = init_cell(i, GRID_W, GRID_H);
            end
        end else if (shift) begin
            seg_d[0] = head_in;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_d[i] = seg_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        seg_q <= seg_d;
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            active[i] = LW'(i) < len;
        end
    end

    assign seg = seg_q;

endmodule

// File: rtl/snake_engine.sv
// Snake game core: step, wrap, grow, self-collision and pixel render.
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60
) (
    input logic           CLK,
    input logic           RESET,
    snake_engine_if.slave bus
);

    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [6:0]    X_MAX   = 7'(GRID_W - 1);
    localparam logic [5:0]    Y_MAX   = 6'(GRID_H - 1);
    localparam logic [6:0]    X_MID   = 7'(GRID_W / 2);
    localparam logic [5:0]    Y_MID   = 6'(GRID_H / 2);
    localparam logic [7:0]    X_LIM   = 8'(GRID_W);
    localparam logic [6:0]    Y_LIM   = 7'(GRID_H);
    localparam logic [LW-1:0] LEN0    = LW'(INIT_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam cell_t         APPLE0  =
        cell_t'({7'(GRID_W / 4), 6'(GRID_H / 4)});

    state_t        state_q, state_d;
    dir_t          hdg_q, hdg_d, hdg_nx;
    cell_t         apple_q, apple_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    colour_q, colour_d;
    logic          reached_q, reached_d;

    cell_t [MAX_LEN-1:0] seg;
    logic  [MAX_LEN-1:0] active;
    logic  [MAX_LEN-1:0] coll_v;
    logic  [MAX_LEN-1:0] body_v;
    cell_t               nx;
    cell_t               pix;
    logic                eat, crash, step;
    logic                init, shift;
    logic                unused_addr;

    snake_segment_shifter #(
        .MAX_LEN (MAX_LEN),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .LW      (LW)
    ) u_seg (
        .CLK     (CLK),
        .RESET   (RESET),
        .init    (init),
        .shift   (shift),
        .head_in (nx),
        .len     (len_q),
        .seg     (seg),
        .active  (active)
    );

    assign pix.x = bus.ADDRH[9:3];
    assign pix.y = bus.ADDRV[8:3];
    assign unused_addr = ^{bus.ADDRH[2:0], bus.ADDRV[2:0]};

    // A reversal request keeps the current heading.
    always_comb begin
        hdg_nx = (bus.DIR == ~hdg_q) ? hdg_q : dir_t'(bus.DIR);
        nx     = seg[0];
        unique case (hdg_nx)
            RIGHT: nx.x = (seg[0].x == X_MAX) ? 7'd0 : seg[0].x + 7'd1;
            LEFT:  nx.x = (seg[0].x == 7'd0) ? X_MAX : seg[0].x - 7'd1;
            DOWN:  nx.y = (seg[0].y == Y_MAX) ? 6'd0 : seg[0].y + 6'd1;
            UP:    nx.y = (seg[0].y == 6'd0) ? Y_MAX : seg[0].y - 6'd1;
        endcase
    end

    // The tail only counts when eating, since it stays put while growing.
    always_comb begin
        eat    = (nx == apple_q);
        coll_v = '0;
        body_v = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            coll_v[i] = active[i] && (seg[i] == nx) &&
                        (eat || (LW'(i) != len_q - 1'b1));
        end
        for (int i = 1; i < MAX_LEN; i++) begin
            body_v[i] = active[i] && (seg[i] == pix);
        end
        crash = |coll_v;
    end

    always_comb begin
        state_d   = state_q;
        hdg_d     = hdg_q;
        apple_d   = apple_q;
        len_d     = len_q;
        score_d   = score_q;
        reached_d = 1'b0;
        init      = 1'b0;
        shift     = 1'b0;
        step      = (state_q == PLAY) && bus.RUN && bus.TICK;
        unique case (state_q)
            IDLE: begin
                init = 1'b1;
                if (bus.RUN) state_d = PLAY;
            end
            PLAY: begin
                if (step && crash) begin
                    state_d = DEAD;
                end else if (step) begin
                    shift = 1'b1;
                    hdg_d = hdg_nx;
                    if (eat) begin
                        reached_d = 1'b1;
                        score_d   = score_q + 8'd1;
                        if (len_q != LEN_MAX) len_d = len_q + 1'b1;
                        apple_d.x = ({1'b0, bus.RAND_X} < X_LIM) ?
                                    bus.RAND_X : X_MID;
                        apple_d.y = ({1'b0, bus.RAND_Y} < Y_LIM) ?
                                    bus.RAND_Y : Y_MID;
                    end
                end
            end
            DEAD: begin
                if (!bus.RUN) begin
                    init    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (init) begin
            hdg_d   = RIGHT;
            apple_d = APPLE0;
            len_d   = LEN0;
            score_d = 8'd0;
        end
    end

    always_comb begin
        if (pix.x > X_MAX || pix.y > Y_MAX) begin
            colour_d = COL_OFF;
        end else if (pix == apple_q) begin
            colour_d = COL_APPLE;
        end else if (pix == seg[0]) begin
            colour_d = (state_q == DEAD) ? COL_DEAD : COL_HEAD;
        end else if (|body_v) begin
            colour_d = COL_BODY;
        end else begin
            colour_d = COL_BG;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            hdg_q     <= RIGHT;
            apple_q   <= APPLE0;
            len_q     <= LEN0;
            score_q   <= 8'd0;
            colour_q  <= COL_OFF;
            reached_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdg_q     <= hdg_d;
            apple_q   <= apple_d;
            len_q     <= len_d;
            score_q   <= score_d;
            colour_q  <= colour_d;
            reached_q <= reached_d;
        end
    end

    assign bus.COLOUR         = colour_q;
    assign bus.REACHED_TARGET = reached_q;
    assign bus.COLLISION      = (state_q == DEAD);
    assign bus.LENGTH         = len_q;
    assign bus.SCORE          = score_q;

endmodule
